downcounter_timer: RTL and testbench

- Loadable down-counter with a start/busy/done handshake, terminal-count pulse, hold, and optional auto-reload.
- Complements the loadable up-counter in the FlipFlops/counter set.
- Used as a programmable interval timer: software or an FSM loads a count, starts it, and waits for done or tc.

---
 rtl/downcounter_timer_if.sv | 25 ++
 rtl/downcounter_timer.sv | 92 +++++++++
 tb/tb_downcounter_timer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/downcounter_timer_if.sv
// Control/status bundle for downcounter_timer: load/start/hold requests in,
// count and handshake status out.
interface downcounter_timer_if #(
   parameter int WIDTH = 4
);
   logic [0:WIDTH-1] d;
   logic             load;
   logic             start;
   logic             hold;
   logic             auto_reload;
   logic [0:WIDTH-1] q;
   logic             busy;
   logic             tc;
   logic             done;

   modport master (
      output d, load, start, hold, auto_reload,
      input  q, busy, tc, done
   );

   modport slave (
      input  d, load, start, hold, auto_reload,
      output q, busy, tc, done
   );
endinterface

// File: rtl/downcounter_timer.sv
// Loadable programmable interval timer: counts down from a loaded value with a
// start/busy/done handshake, terminal-count pulse, hold and optional auto-reload.
module downcounter_timer #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   downcounter_timer_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state;
   logic [0:WIDTH-1] q_r;
   logic [0:WIDTH-1] reload_r;
   logic             busy_r;
   logic             tc_r;
   logic             done_r;

   wire q_zero = (q_r == '0);
   wire q_one  = (q_r == WIDTH'(1));

   // NOTE: all state lives in one clocked block with non-blocking assignments,
   // so every read below sees the pre-edge value regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         q_r      <= '0;
         reload_r <= '0;
         busy_r   <= 1'b0;
         tc_r     <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         // tc and done are single-cycle pulses; they only rise where set below.
         tc_r   <= 1'b0;
         done_r <= 1'b0;

         if (bus.load) begin
            q_r      <= bus.d;
            reload_r <= bus.d;
            state    <= IDLE;
            busy_r   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start) begin
                     if (q_zero) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                     end else begin
                        state  <= RUN;
                        busy_r <= 1'b1;
                     end
                  end
               end

               RUN: begin
                  if (!bus.hold) begin
                     if (!q_zero) begin
                        q_r  <= q_r - 1'b1;
                        tc_r <= q_one;
                     end else if (bus.auto_reload && (reload_r != '0)) begin
                        q_r <= reload_r;
                     end else begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                     end
                  end
               end

               DONE: state <= IDLE;

               default: begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.q    = q_r;
   assign bus.busy = busy_r;
   assign bus.tc   = tc_r;
   assign bus.done = done_r;

endmodule

// File: tb/tb_downcounter_timer.sv
// Scoreboard bench for downcounter_timer: the stimulus process queues the
// hand-computed post-edge outputs, a monitor pops and compares after each edge.
module tb_downcounter_timer;

   localparam int WIDTH = 4;

   typedef struct {
      string          name;
      logic [WIDTH:0] unused_pad;
      logic [WIDTH-1:0] q;
      logic           busy;
      logic           tc;
      logic           done;
   } exp_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   exp_t sb[$];

   downcounter_timer_if #(.WIDTH(WIDTH)) bus ();

   downcounter_timer #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [WIDTH+2:0] act,
                        input logic [WIDTH+2:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got q=%0d busy=%b tc=%b done=%b, want q=%0d busy=%b tc=%b done=%b",
                  name, act[WIDTH+2:3], act[2], act[1], act[0],
                  exp[WIDTH+2:3], exp[2], exp[1], exp[0]);
      end
   endtask

   function automatic logic [WIDTH+2:0] pack_dut();
      return {bus.q, bus.busy, bus.tc, bus.done};
   endfunction

   // One clock of stimulus plus the outputs expected right after that edge.
   task automatic step(input string nm, input bit ld, input logic [WIDTH-1:0] dv,
                       input bit st, input bit hd, input bit ar,
                       input logic [WIDTH-1:0] eq, input bit eb, input bit et, input bit ed);
      exp_t e;
      @(negedge clk);
      bus.load        = ld;
      bus.d           = dv;
      bus.start       = st;
      bus.hold        = hd;
      bus.auto_reload = ar;
      e.name = nm;
      e.unused_pad = '0;
      e.q = eq;
      e.busy = eb;
      e.tc = et;
      e.done = ed;
      sb.push_back(e);
   endtask

   // Monitor: compares once per edge, after outputs have settled.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.name, pack_dut(), {e.q, e.busy, e.tc, e.done});
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      bus.load = 1'b0; bus.d = '0; bus.start = 1'b0;
      bus.hold = 1'b0; bus.auto_reload = 1'b0;

      // Reset asserted between edges must clear outputs immediately.
      #2 rst = 1'b1;
      #1 check("reset_async", pack_dut(), '0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      //    name           ld d  st hd ar   q  b  tc dn
      step("idle0",        0, 0, 0, 0, 0,   0, 0, 0, 0);
      step("idle1",        0, 0, 0, 0, 0,   0, 0, 0, 0);

      // Basic run from 6.
      step("b_load",       1, 6, 0, 0, 0,   6, 0, 0, 0);
      step("b_start",      0, 0, 1, 0, 0,   6, 1, 0, 0);
      step("b_5",          0, 0, 0, 0, 0,   5, 1, 0, 0);
      step("b_4",          0, 0, 0, 0, 0,   4, 1, 0, 0);
      step("b_3",          0, 0, 0, 0, 0,   3, 1, 0, 0);
      step("b_2",          0, 0, 0, 0, 0,   2, 1, 0, 0);
      step("b_1",          0, 0, 0, 0, 0,   1, 1, 0, 0);
      step("b_tc",         0, 0, 0, 0, 0,   0, 1, 1, 0);
      step("b_done",       0, 0, 0, 0, 0,   0, 0, 0, 1);
      step("b_idle",       0, 0, 0, 0, 0,   0, 0, 0, 0);

      // Hold for three cycles at q=3.
      step("h_load",       1, 5, 0, 0, 0,   5, 0, 0, 0);
      step("h_start",      0, 0, 1, 0, 0,   5, 1, 0, 0);
      step("h_4",          0, 0, 0, 0, 0,   4, 1, 0, 0);
      step("h_3",          0, 0, 0, 0, 0,   3, 1, 0, 0);
      step("h_hold1",      0, 0, 0, 1, 0,   3, 1, 0, 0);
      step("h_hold2",      0, 0, 1, 1, 0,   3, 1, 0, 0);
      step("h_hold3",      0, 0, 0, 1, 0,   3, 1, 0, 0);
      step("h_2",          0, 0, 0, 0, 0,   2, 1, 0, 0);
      step("h_1",          0, 0, 0, 0, 0,   1, 1, 0, 0);
      step("h_tc",         0, 0, 0, 0, 0,   0, 1, 1, 0);
      step("h_done",       0, 0, 0, 0, 0,   0, 0, 0, 1);
      step("h_idle",       0, 0, 0, 0, 0,   0, 0, 0, 0);

      // Auto-reload from 3, hold at q=0 defers the decision, then finish.
      step("a_load",       1, 3, 0, 0, 1,   3, 0, 0, 0);
      step("a_start",      0, 0, 1, 0, 1,   3, 1, 0, 0);
      step("a_2",          0, 0, 0, 0, 1,   2, 1, 0, 0);
      step("a_1",          0, 0, 0, 0, 1,   1, 1, 0, 0);
      step("a_tc1",        0, 0, 0, 0, 1,   0, 1, 1, 0);
      step("a_reload",     0, 0, 0, 0, 1,   3, 1, 0, 0);
      step("a_2b",         0, 0, 0, 0, 1,   2, 1, 0, 0);
      step("a_1b",         0, 0, 0, 0, 1,   1, 1, 0, 0);
      step("a_tc2",        0, 0, 0, 0, 0,   0, 1, 1, 0);
      step("a_hold0",      0, 0, 0, 1, 0,   0, 1, 0, 0);
      step("a_done",       0, 0, 0, 0, 0,   0, 0, 0, 1);
      step("a_idle",       0, 0, 0, 0, 0,   0, 0, 0, 0);

      // Load mid-run aborts; start in RUN is ignored.
      step("l_load9",      1, 9, 0, 0, 0,   9, 0, 0, 0);
      step("l_start",      0, 0, 1, 0, 0,   9, 1, 0, 0);
      step("l_8",          0, 0, 1, 0, 0,   8, 1, 0, 0);
      step("l_7",          0, 0, 0, 0, 0,   7, 1, 0, 0);
      step("l_6",          0, 0, 0, 0, 0,   6, 1, 0, 0);
      step("l_5",          0, 0, 0, 0, 0,   5, 1, 0, 0);
      step("l_load4",      1, 4, 0, 0, 0,   4, 0, 0, 0);
      step("l_idle",       0, 0, 0, 0, 0,   4, 0, 0, 0);
      step("l_start4",     0, 0, 1, 0, 0,   4, 1, 0, 0);
      step("l_3",          0, 0, 0, 0, 0,   3, 1, 0, 0);
      step("l_2",          0, 0, 0, 0, 0,   2, 1, 0, 0);
      step("l_1",          0, 0, 0, 0, 0,   1, 1, 0, 0);
      step("l_tc",         0, 0, 0, 0, 0,   0, 1, 1, 0);
      step("l_done",       0, 0, 0, 0, 0,   0, 0, 0, 1);

      // Zero start, then load/start collision.
      step("z_load0",      1, 0, 0, 0, 0,   0, 0, 0, 0);
      step("z_start",      0, 0, 1, 0, 0,   0, 0, 0, 1);
      step("z_idle",       0, 0, 0, 0, 0,   0, 0, 0, 0);
      step("c_loadstart",  1, 2, 1, 0, 0,   2, 0, 0, 0);
      step("c_idle",       0, 0, 0, 0, 0,   2, 0, 0, 0);

      // Start held through DONE is ignored; DONE always returns to IDLE.
      step("d_load1",      1, 1, 0, 0, 0,   1, 0, 0, 0);
      step("d_start",      0, 0, 1, 0, 0,   1, 1, 0, 0);
      step("d_tc",         0, 0, 1, 0, 0,   0, 1, 1, 0);
      step("d_done",       0, 0, 1, 0, 0,   0, 0, 0, 1);
      step("d_idle",       0, 0, 1, 0, 0,   0, 0, 0, 0);

      // Mid-run asynchronous reset.
      step("r_load7",      1, 7, 0, 0, 0,   7, 0, 0, 0);
      step("r_start",      0, 0, 1, 0, 0,   7, 1, 0, 0);
      step("r_6",          0, 0, 0, 0, 0,   6, 1, 0, 0);
      @(posedge clk);
      #4 rst = 1'b1;
      #1 check("reset_midrun", pack_dut(), '0);
      @(negedge clk);
      rst = 1'b0;
      step("r_after",      0, 0, 0, 0, 0,   0, 0, 0, 0);
      step("r_nofresh",    0, 0, 1, 0, 0,   0, 0, 0, 1);
      step("r_idle",       0, 0, 0, 0, 0,   0, 0, 0, 0);

      // Bounded drain: every queued expectation must have been consumed.
      repeat (3) @(posedge clk);
      #3 check("drain", (WIDTH+3)'(sb.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
